// File: rtl/flag_register_unit.sv
// flag_register_unit: Z80 F/F' flag registers with masked ALU update, load, swap, SCF/CCF and cc evaluation.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset, loads RESET_VALUE into F and F'
//   alu_status   - ALU status flags {S,Z,Y,H,X,P/V,N,C}
//   alu_result   - ALU result, supplies Y/X only when FLAG_XY_EN is defined
//   update_en    - capture alu_status into F under update_mask
//   update_mask  - per-bit write enable for update_en
//   load_en      - load load_data into F (POP AF)
//   load_data    - full F value for load_en
//   swap_af      - exchange F and F' (EX AF,AF')
//   scf / ccf    - set / complement carry flag
//   cond         - condition code: NZ,Z,NC,C,PO,PE,P,M
//   flags        - current F
//   flags_shadow - current F'
//   cond_true    - cond evaluated against current F
//
// Optional feature macro FLAG_XY_EN: when defined, Y/X (bits 5/3) come from
// alu_result on update_en, scf and ccf; otherwise update_en writes them as 0
// and scf/ccf leave them untouched.
module flag_register_unit #(
    parameter logic [7:0] RESET_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_status,
    input  logic [7:0] alu_result,
    input  logic       update_en,
    input  logic [7:0] update_mask,
    input  logic       load_en,
    input  logic [7:0] load_data,
    input  logic       swap_af,
    input  logic       scf,
    input  logic       ccf,
    input  logic [2:0] cond,
    output logic [7:0] flags,
    output logic [7:0] flags_shadow,
    output logic       cond_true
);
    localparam int S = 7, Z = 6, Y = 5, H = 4, X = 3, PV = 2, N = 1, C = 0;

    logic [7:0] f_q, f_d, fs_q, fs_d, upd_src;
    logic       cond_sel;

`ifdef FLAG_XY_EN
    assign upd_src = {alu_status[7:6], alu_result[5], alu_status[4], alu_result[3], alu_status[2:0]};
`else
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result;
    assign upd_src = alu_status & 8'b1101_0111;
`endif

    // Priority ladder: only the highest asserted command takes effect.
    always_comb begin
        f_d  = f_q;
        fs_d = fs_q;
        if (load_en) begin
            f_d = load_data;
        end else if (swap_af) begin
            f_d  = fs_q;
            fs_d = f_q;
        end else if (update_en) begin
            f_d = (f_q & ~update_mask) | (upd_src & update_mask);
        end else if (scf || ccf) begin
            f_d[C] = scf ? 1'b1 : ~f_q[C];
            f_d[H] = scf ? 1'b0 : f_q[C];
            f_d[N] = 1'b0;
`ifdef FLAG_XY_EN
            f_d[Y] = alu_result[5];
            f_d[X] = alu_result[3];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q  <= RESET_VALUE;
            fs_q <= RESET_VALUE;
        end else begin
            f_q  <= f_d;
            fs_q <= fs_d;
        end
    end

    // cond[2:1] picks the flag (Z, C, P/V, S); cond[0] selects true vs. complemented sense.
    always_comb begin
        cond_sel  = cond[2] ? (cond[1] ? f_q[S] : f_q[PV]) : (cond[1] ? f_q[C] : f_q[Z]);
        cond_true = cond[0] ? cond_sel : ~cond_sel;
    end

    assign flags        = f_q;
    assign flags_shadow = fs_q;
endmodule

// File: tb/tb_flag_register_unit.sv
// tb_flag_register_unit: directed and randomized checks of flag_register_unit against a behavioural model.
module tb_flag_register_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_status = '0, alu_result = '0, update_mask = '0, load_data = '0;
    logic       update_en = 1'b0, load_en = 1'b0, swap_af = 1'b0, scf = 1'b0, ccf = 1'b0;
    logic [2:0] cond = '0;
    logic [7:0] flags, flags_shadow;
    logic       cond_true;

    int passed = 0, total = 0;
    logic [7:0] mf = 8'hFF, ms = 8'hFF;

    flag_register_unit dut (
        .clk(clk), .rst_n(rst_n), .alu_status(alu_status), .alu_result(alu_result),
        .update_en(update_en), .update_mask(update_mask), .load_en(load_en),
        .load_data(load_data), .swap_af(swap_af), .scf(scf), .ccf(ccf), .cond(cond),
        .flags(flags), .flags_shadow(flags_shadow), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    function automatic logic cond_model(input logic [7:0] f, input logic [2:0] c);
        logic s, z, p, cy;
        s = f[7]; z = f[6]; p = f[2]; cy = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !cy;
            3'd3: return cy;
            3'd4: return !p;
            3'd5: return p;
            3'd6: return !s;
            default: return s;
        endcase
    endfunction

    // Drive one cycle of commands, advance the model, land #1 after the edge.
    task automatic cycle(input logic ld, input logic [7:0] ldd, input logic sw, input logic up,
                         input logic [7:0] st, input logic [7:0] mk, input logic [7:0] res,
                         input logic s, input logic c);
        logic [7:0] t;
        logic old_c;
        load_en = ld; load_data = ldd; swap_af = sw; update_en = up;
        alu_status = st; update_mask = mk; alu_result = res; scf = s; ccf = c;
        if (ld) mf = ldd;
        else if (sw) begin t = mf; mf = ms; ms = t; end
        else if (up) begin
            for (int i = 0; i < 8; i++)
                if (mk[i]) begin
                    if (i == 5 || i == 3) begin
`ifdef FLAG_XY_EN
                        mf[i] = res[i];
`else
                        mf[i] = 1'b0;
`endif
                    end else mf[i] = st[i];
                end
        end else if (s || c) begin
            old_c = mf[0];
            mf[0] = s ? 1'b1 : !old_c;
            mf[4] = s ? 1'b0 : old_c;
            mf[1] = 1'b0;
`ifdef FLAG_XY_EN
            mf[5] = res[5];
            mf[3] = res[3];
`endif
        end
        @(posedge clk);
        #1;
        load_en = 0; swap_af = 0; update_en = 0; scf = 0; ccf = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        mf = 8'hFF; ms = 8'hFF;
        total++; if (flags !== 8'hFF) $display("FAIL reset_flags got=%h exp=ff", flags); else passed++;
        total++; if (flags_shadow !== 8'hFF) $display("FAIL reset_shadow got=%h exp=ff", flags_shadow); else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cond = 3'd1; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL reset_cond_z got=%b exp=1", cond_true); else passed++;
        cond = 3'd0; #1;
        total++; if (cond_true !== 1'b0) $display("FAIL reset_cond_nz got=%b exp=0", cond_true); else passed++;
    endtask

    task automatic test_masked_update();
        cycle(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 8'b0100_0010, 8'hFF, 8'hFF, 0, 0);
        total++; if (flags !== 8'h42) $display("FAIL upd_full got=%h exp=42", flags); else passed++;
        cond = 3'd1; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL upd_cond_z got=%b exp=1", cond_true); else passed++;
        cycle(0, 0, 0, 1, 8'b1001_0100, 8'h01, 8'hFF, 0, 0);
        total++; if (flags !== 8'h42) $display("FAIL upd_mask1 got=%h exp=42", flags); else passed++;
        cycle(0, 0, 0, 1, 8'hFF, 8'h00, 8'hFF, 0, 0);
        total++; if (flags !== 8'h42) $display("FAIL upd_mask0 got=%h exp=42", flags); else passed++;
        cycle(0, 0, 0, 1, 8'hFF, 8'b0010_1000, 8'h00, 0, 0);
        total++; if (flags !== mf) $display("FAIL upd_xy got=%h exp=%h", flags, mf); else passed++;
    endtask

    task automatic test_carry_ops();
        cycle(1, 8'h42, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        total++; if (flags !== 8'h41) $display("FAIL scf got=%h exp=41", flags); else passed++;
        cond = 3'd3; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL scf_cond_c got=%b exp=1", cond_true); else passed++;
        cycle(0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        total++; if (flags !== 8'h50) $display("FAIL ccf got=%h exp=50", flags); else passed++;
        cond = 3'd2; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL ccf_cond_nc got=%b exp=1", cond_true); else passed++;
        cycle(0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        total++; if (flags !== 8'h41) $display("FAIL ccf2 got=%h exp=41", flags); else passed++;
    endtask

    task automatic test_shadow_swap();
        cycle(1, 8'h81, 0, 0, 0, 0, 0, 0, 0);
        total++; if (flags_shadow !== 8'hFF) $display("FAIL load_shadow got=%h exp=ff", flags_shadow); else passed++;
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (flags !== 8'hFF) $display("FAIL swap1_flags got=%h exp=ff", flags); else passed++;
        total++; if (flags_shadow !== 8'h81) $display("FAIL swap1_shadow got=%h exp=81", flags_shadow); else passed++;
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (flags !== 8'h81) $display("FAIL swap2_flags got=%h exp=81", flags); else passed++;
        total++; if (flags_shadow !== 8'hFF) $display("FAIL swap2_shadow got=%h exp=ff", flags_shadow); else passed++;
        cond = 3'd7; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL swap_cond_m got=%b exp=1", cond_true); else passed++;
    endtask

    task automatic test_priority();
        cycle(1, 8'h01, 1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1);
        total++; if (flags !== 8'h01) $display("FAIL prio_flags got=%h exp=01", flags); else passed++;
        total++; if (flags_shadow !== 8'hFF) $display("FAIL prio_shadow got=%h exp=ff", flags_shadow); else passed++;
        cycle(0, 0, 1, 1, 8'h00, 8'hFF, 8'h00, 1, 0);
        total++; if (flags !== 8'hFF || flags_shadow !== 8'h01)
            $display("FAIL prio_swap got=%h/%h exp=ff/01", flags, flags_shadow); else passed++;
        cycle(0, 0, 0, 1, 8'h00, 8'hFF, 8'h00, 1, 1);
        total++; if (flags !== 8'h00) $display("FAIL prio_upd got=%h exp=00", flags); else passed++;
        cycle(0, 0, 0, 0, 0, 0, 8'h00, 1, 1);
        total++; if (flags !== 8'h01) $display("FAIL prio_scf got=%h exp=01", flags); else passed++;
    endtask

    task automatic test_reset_mid_swap();
        cycle(1, 8'h20, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 8'h10, 0, 0, 0, 0, 0, 0, 0);
        total++; if (flags !== 8'h10 || flags_shadow !== 8'h20)
            $display("FAIL midswap_setup got=%h/%h exp=10/20", flags, flags_shadow); else passed++;
        swap_af = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++; if (flags !== 8'hFF || flags_shadow !== 8'hFF)
            $display("FAIL midswap_async got=%h/%h exp=ff/ff", flags, flags_shadow); else passed++;
        @(posedge clk); #1;
        total++; if (flags !== 8'hFF || flags_shadow !== 8'hFF)
            $display("FAIL midswap_edge got=%h/%h exp=ff/ff", flags, flags_shadow); else passed++;
        swap_af = 1'b0;
        mf = 8'hFF; ms = 8'hFF;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (flags !== 8'hFF || flags_shadow !== 8'hFF)
            $display("FAIL midswap_post got=%h/%h exp=ff/ff", flags, flags_shadow); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            cond = 3'($urandom);
            #1;
            total++; if (flags !== mf) $display("FAIL rnd_flags n=%0d got=%h exp=%h", n, flags, mf); else passed++;
            total++; if (flags_shadow !== ms) $display("FAIL rnd_shadow n=%0d got=%h exp=%h", n, flags_shadow, ms); else passed++;
            total++; if (cond_true !== cond_model(mf, cond))
                $display("FAIL rnd_cond n=%0d cc=%0d got=%b exp=%b", n, cond, cond_true, cond_model(mf, cond)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_masked_update();
        test_carry_ops();
        test_shadow_swap();
        test_priority();
        test_reset_mid_swap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
- Consumer end of the ALU status interface. Latches the 8-bit `status_flag` output of `alu` into the architectural Z80 F register, under a per-bit write mask.
- Holds the F' shadow register for EX AF,AF'.
- Accepts F loads from the data path (POP AF) and executes SCF/CCF.
- Evaluates the 3-bit Z80 condition code for JP/JR/CALL/RET cc. Sits between the ALU and the control/sequencer.

Parameters:
- RESET_VALUE, 8'hFF, value loaded into F and F' on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_status  input  8  ALU `status_flag`; layout {S,Z,Y,H,X,P/V,N,C}, bit 7 = S.
- alu_result  input  8  ALU `out`; used only with FLAG_XY_EN.
- update_en  input  1  capture alu_status into F this cycle.
- update_mask  input  8  per-bit enable for update_en; 1 = bit written, 0 = bit held.
- load_en  input  1  load load_data into F (POP AF / LD from bus).
- load_data  input  8  full F value for load_en.
- swap_af  input  1  exchange F and F'.
- scf  input  1  set carry flag.
- ccf  input  1  complement carry flag.
- cond  input  3  condition: 0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M.
- flags  output  8  current F.
- flags_shadow  output  8  current F'.
- cond_true  output  1  cond evaluated against current F.

Behaviour:
- Reset:
  - rst_n low asynchronously forces F = F' = RESET_VALUE.
  - flags and flags_shadow reflect RESET_VALUE immediately.
  - cond_true follows combinationally.
  - Deassertion is honoured at the next rising edge.
- All state changes occur on the rising clk edge. Outputs are registered values; there is no same-cycle bypass of alu_status.
- Command priority per cycle, highest first: load_en > swap_af > update_en > scf > ccf. Only the highest asserted command takes effect; the others are dropped with no queuing.
- load_en: F <= load_data, all 8 bits written, mask ignored. F' unchanged.
- swap_af: F <= F', F' <= F in one cycle. A second swap on the next cycle restores the original values.
- update_en, per bit i: F[i] <= update_mask[i] ? alu_status[i] : F[i].
  - Bits 5 and 3 are always written as 0 when masked in, unless FLAG_XY_EN is defined.
  - update_mask = 0 leaves F unchanged; this is legal.
- scf: C <= 1, H <= 0, N <= 0; all other bits held.
- ccf: H <= old C, C <= ~old C, N <= 0; all other bits held.
- cond_true is combinational from registered F:
  - NZ = ~Z, Z = Z, NC = ~C, C = C.
  - PO = ~P/V, PE = P/V, P = ~S, M = S.
- Latency: a command in cycle n is visible on flags and cond_true in cycle n+1.
- No command asserted: F and F' hold indefinitely.
- Reset asserted mid-command (including during swap_af): the command is discarded and both registers take RESET_VALUE.
- F' is never written by update_en, load_en, scf or ccf.

Optional Feature:
- Macro: FLAG_XY_EN.
- Defined: on update_en, Y (bit 5) <= alu_result[5] and X (bit 3) <= alu_result[3], each gated by its mask bit.
  - scf/ccf: Y/X <= corresponding bits of alu_result, modelling undocumented behaviour. The sequencer presents A on alu_result for these commands.
- Undefined:
  - update_en writes masked-in bits 5/3 as 0.
  - scf/ccf leave bits 5/3 unchanged.
  - alu_result is unused; lint waiver is permitted.

Test Plan:
- Reset:
  - Stimulus: hold rst_n low mid-cycle.
  - Response: flags = flags_shadow = 8'hFF immediately.
  - After release: cond=1 (Z) gives cond_true = 1; cond=0 (NZ) gives 0.
- Masked update:
  - Stimulus: F = 8'h00; update_en, alu_status = 8'b01000010, mask = 8'hFF.
  - Response: next cycle flags = 8'h42, cond=1 gives cond_true = 1.
  - Then alu_status = 8'b10010100, mask = 8'h01: flags stays 8'h42 (C bit written 0).
- Carry ops:
  - Stimulus: F = 8'h42; scf.
  - Response: flags = 8'h41, cond=3 gives 1.
  - Then ccf: flags = 8'h50 (H = 1, C = 0), cond=2 gives 1.
- Shadow swap:
  - Stimulus: load_en with 8'h81; swap_af.
  - Response: flags = 8'hFF, flags_shadow = 8'h81.
  - Second swap restores flags = 8'h81; cond=7 (M) gives 1.
- Priority:
  - Stimulus: load_en = 8'h01, swap_af, update_en (alu_status 8'hFF, mask 8'hFF) and scf all in one cycle.
  - Response: flags = 8'h01, flags_shadow unchanged.
- Reset mid-swap:
  - Stimulus: F = 8'h10, F' = 8'h20; assert swap_af and drop rst_n before the edge.
  - Response: both registers read 8'hFF; no partial swap visible.
